vram_arbiter: RTL and testbench

//  Shares the single-port 16K x 16 video RAM (text cells at 0x0000-0x1FFF, glyphs from 0x2000)

---
 rtl/vram_arbiter_pkg.sv | 18 +
 rtl/vram_arbiter_if.sv | 43 ++++
 rtl/vram_arbiter_wr_fifo.sv | 56 +++++
 rtl/vram_arbiter.sv | 142 ++++++++++++++
 tb/tb_vram_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared constants and read-FSM state type for the VRAM arbiter slice.
package vram_arbiter_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W = 16;
  localparam int unsigned VRAM_WR_DEPTH = 4;

  // Text cells occupy 0x0000-0x1FFF, glyph rows start here.
  localparam logic [VRAM_ADDR_W-1:0] VRAM_GLYPH_BASE = 14'h2000;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Display, host and RAM-side signals of the VRAM arbiter; slave = arbiter, master = clients/RAM.
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic              disp_rd_en;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_wr_valid;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_wr_ready;

  logic              host_rd_req;
  logic [ADDR_W-1:0] host_rd_addr;
  logic              host_rd_busy;
  logic              host_rd_valid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_rd_en, disp_addr, host_wr_valid, host_wr_addr, host_wr_data,
           host_rd_req, host_rd_addr, mem_rdata,
    output disp_rdata, host_wr_ready, host_rd_busy, host_rd_valid, host_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_rd_en, disp_addr, host_wr_valid, host_wr_addr, host_wr_data,
           host_rd_req, host_rd_addr, mem_rdata,
    input  disp_rdata, host_wr_ready, host_rd_busy, host_rd_valid, host_rdata,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// Host write buffer: synchronous FIFO of {addr,data} words, head visible without a pop.
module vram_wr_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display reads always win; buffered host writes then single host reads use idle cycles.
// Optional VRAM_ARB_STATS_EN adds saturating stall_cnt / wr_blocked_cnt outputs.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned DATA_W   = VRAM_DATA_W,
  parameter int unsigned WR_DEPTH = VRAM_WR_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]    stall_cnt,
  output logic [15:0]    wr_blocked_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(WR_DEPTH) + 1;

  rd_state_e           r_state;
  rd_state_e           w_state_nxt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_rdata;

  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_rd_issue;
  logic                w_rd_capture;
  logic                w_busy;
  logic                w_valid;

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (WR_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({bus.host_wr_addr, bus.host_wr_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_head_addr, w_head_data} = w_head;

  assign w_push            = bus.host_wr_valid && !w_full;
  assign bus.host_wr_ready = !w_full;
  assign bus.mem_wdata     = w_head_data;
  assign bus.disp_rdata    = bus.mem_rdata;
  assign bus.host_rd_busy  = w_busy;
  assign bus.host_rd_valid = w_valid;
  assign bus.host_rdata    = r_rdata;

  // Grant mux; a pending read waits behind any buffered write so host reads see prior writes.
  always_comb begin
    bus.mem_addr = bus.disp_addr;
    bus.mem_we   = 1'b0;
    w_pop        = 1'b0;
    w_rd_issue   = 1'b0;
    if (bus.disp_rd_en) begin
      bus.mem_addr = bus.disp_addr;
    end else if (!w_empty) begin
      bus.mem_addr = w_head_addr;
      bus.mem_we   = 1'b1;
      w_pop        = 1'b1;
    end else if (r_state == RD_PEND) begin
      bus.mem_addr = r_rd_addr;
      w_rd_issue   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = 1'b0;
    w_valid      = 1'b0;
    w_rd_capture = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_rd_capture = bus.host_rd_req;
        if (bus.host_rd_req) w_state_nxt = RD_PEND;
      end
      RD_PEND: begin
        w_busy = 1'b1;
        if (w_rd_issue) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_busy      = 1'b1;
        w_state_nxt = RD_DONE;
      end
      RD_DONE: begin
        w_valid      = 1'b1;
        w_rd_capture = bus.host_rd_req;
        w_state_nxt  = bus.host_rd_req ? RD_PEND : RD_IDLE;
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_rd_addr <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_capture)        r_rd_addr <= bus.host_rd_addr;
      if (r_state == RD_WAIT)  r_rdata   <= bus.mem_rdata;
    end
  end

  a_fifo_count_bound: assert property (@(posedge clk) disable iff (rst) w_count <= CNT_W'(WR_DEPTH));

`ifdef VRAM_ARB_STATS_EN
  logic w_host_pending;

  assign w_host_pending = !w_empty || (r_state == RD_PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt      <= '0;
      wr_blocked_cnt <= '0;
    end else begin
      if (bus.disp_rd_en && w_host_pending && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (bus.host_wr_valid && w_full && (wr_blocked_cnt != '1))
        wr_blocked_cnt <= wr_blocked_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table vectors, corner sequences and random traffic vs. a queue model.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(VRAM_ADDR_W), .DATA_W(VRAM_DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W   (VRAM_ADDR_W),
    .DATA_W   (VRAM_DATA_W),
    .WR_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port RAM, read-first, one cycle read latency.
  logic [15:0] ram [16384];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  typedef struct { logic [13:0] a; logic [15:0] d; } wr_t;
  wr_t         wq[$];
  logic [15:0] shadow [int];
  bit          rd_out, rd_issued;
  int          issue_cyc;
  int          cyc = 0;
  logic [13:0] rd_a;
  logic [15:0] rd_exp, exp_hrd, exp_disp;
  bit          disp_chk;

  typedef struct {
    logic de; logic [13:0] da; logic wv; logic [13:0] wa; logic [15:0] wd;
    logic we; logic [13:0] addr; logic [15:0] wdata; logic rdy;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] pool(input int unsigned i);
    logic [13:0] a;
    a = 14'(i % 8);
    if (((i / 8) % 2) == 1) a = a | VRAM_GLYPH_BASE;
    return a;
  endfunction

  task automatic model_reset();
    wq.delete();
    rd_out   = 0;
    rd_issued = 0;
    exp_hrd  = '0;
    disp_chk = 0;
  endtask

  task automatic model_step();
    bit exp_rdy, exp_busy, exp_vld;
    wr_t w;
    exp_rdy  = wq.size() < DEPTH;
    exp_vld  = rd_out && rd_issued && (cyc == issue_cyc + 2);
    exp_busy = rd_out && !exp_vld;
    if (exp_vld) begin
      exp_hrd = rd_exp;
      rd_out  = 0;
    end
    chk("wr_ready", 32'(bus.host_wr_ready), 32'(exp_rdy));
    chk("rd_busy", 32'(bus.host_rd_busy), 32'(exp_busy));
    chk("rd_valid", 32'(bus.host_rd_valid), 32'(exp_vld));
    chk("host_rdata", 32'(bus.host_rdata), 32'(exp_hrd));
    if (disp_chk) chk("disp_rdata", 32'(bus.disp_rdata), 32'(exp_disp));
    disp_chk = 0;
    if (bus.disp_rd_en) begin
      chk("disp_we", 32'(bus.mem_we), 32'd0);
      chk("disp_addr", 32'(bus.mem_addr), 32'(bus.disp_addr));
      if (shadow.exists(int'(bus.disp_addr))) begin
        disp_chk = 1;
        exp_disp = shadow[int'(bus.disp_addr)];
      end
    end else if (wq.size() != 0) begin
      w = wq.pop_front();
      chk("wr_we", 32'(bus.mem_we), 32'd1);
      chk("wr_addr", 32'(bus.mem_addr), 32'(w.a));
      chk("wr_data", 32'(bus.mem_wdata), 32'(w.d));
      shadow[int'(w.a)] = w.d;
    end else if (rd_out && !rd_issued) begin
      chk("rd_we", 32'(bus.mem_we), 32'd0);
      chk("rd_addr", 32'(bus.mem_addr), 32'(rd_a));
      rd_issued = 1;
      issue_cyc = cyc;
      rd_exp    = shadow.exists(int'(rd_a)) ? shadow[int'(rd_a)] : 'x;
    end else begin
      chk("idle_we", 32'(bus.mem_we), 32'd0);
      chk("idle_addr", 32'(bus.mem_addr), 32'(bus.disp_addr));
    end
    if (bus.host_rd_req && !exp_busy) begin
      rd_out    = 1;
      rd_issued = 0;
      rd_a      = bus.host_rd_addr;
    end
    if (bus.host_wr_valid && exp_rdy) wq.push_back('{a: bus.host_wr_addr, d: bus.host_wr_data});
    cyc++;
  endtask

  task automatic drive(input logic de, input logic [13:0] da, input logic wv,
                       input logic [13:0] wa, input logic [15:0] wd,
                       input logic rq, input logic [13:0] ra);
    bus.disp_rd_en    = de;
    bus.disp_addr     = da;
    bus.host_wr_valid = wv;
    bus.host_wr_addr  = wa;
    bus.host_wr_data  = wd;
    bus.host_rd_req   = rq;
    bus.host_rd_addr  = ra;
  endtask

  task automatic cycle(input logic de, input logic [13:0] da, input logic wv,
                       input logic [13:0] wa, input logic [15:0] wd,
                       input logic rq, input logic [13:0] ra);
    @(posedge clk);
    #1;
    drive(de, da, wv, wa, wd, rq, ra);
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, 1'b0, 14'h0);
  endtask

  initial begin
    int unsigned n;
    int unsigned cnt;
    logic        de;

    tbl[0] = '{1'b1, 14'h0100, 1'b1, 14'h0010, 16'hA000, 1'b0, 14'h0100, 16'h0000, 1'b1};
    tbl[1] = '{1'b1, 14'h0101, 1'b1, 14'h0011, 16'hA001, 1'b0, 14'h0101, 16'h0000, 1'b1};
    tbl[2] = '{1'b1, 14'h0102, 1'b1, 14'h0012, 16'hA002, 1'b0, 14'h0102, 16'h0000, 1'b1};
    tbl[3] = '{1'b1, 14'h0103, 1'b1, 14'h0013, 16'hA003, 1'b0, 14'h0103, 16'h0000, 1'b1};
    tbl[4] = '{1'b1, 14'h0104, 1'b1, 14'h0014, 16'hA004, 1'b0, 14'h0104, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 14'h0200, 1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0010, 16'hA000, 1'b0};
    tbl[6] = '{1'b0, 14'h0201, 1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0011, 16'hA001, 1'b1};
    tbl[7] = '{1'b0, 14'h0202, 1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0012, 16'hA002, 1'b1};
    tbl[8] = '{1'b0, 14'h0203, 1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0013, 16'hA003, 1'b1};
    tbl[9] = '{1'b0, 14'h0204, 1'b0, 14'h0000, 16'h0000, 1'b0, 14'h0204, 16'h0000, 1'b1};

    drive(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, 1'b0, 14'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Reset while a read is in RD_WAIT and a write is still buffered
    cycle(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, 1'b1, 14'h0005);
    cycle(1'b0, 14'h0, 1'b1, 14'h0030, 16'h1234, 1'b0, 14'h0);
    cycle(1'b1, 14'h0007, 1'b0, 14'h0, 16'h0, 1'b0, 14'h0);
    chk("pre_rst_busy", 32'(bus.host_rd_busy), 32'd1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    drive(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, 1'b0, 14'h0);
    @(negedge clk);
    model_step();
    idle(4);

    // Write burst against a busy display, then drain
    for (int unsigned i = 0; i < 10; i++) begin
      cycle(tbl[i].de, tbl[i].da, tbl[i].wv, tbl[i].wa, tbl[i].wd, 1'b0, 14'h0);
      chk("tbl_we", 32'(bus.mem_we), 32'(tbl[i].we));
      chk("tbl_addr", 32'(bus.mem_addr), 32'(tbl[i].addr));
      if (tbl[i].we) chk("tbl_wdata", 32'(bus.mem_wdata), 32'(tbl[i].wdata));
      chk("tbl_ready", 32'(bus.host_wr_ready), 32'(tbl[i].rdy));
    end

    // Display read pass-through
    cycle(1'b0, 14'h0, 1'b1, 14'h0041, 16'h1F48, 1'b0, 14'h0);
    idle(1);
    cycle(1'b1, 14'h0041, 1'b0, 14'h0, 16'h0, 1'b0, 14'h0);
    idle(1);
    chk("disp_rdata_0041", 32'(bus.disp_rdata), 32'h1F48);

    // Read right behind a write to the same glyph address
    cycle(1'b0, 14'h0, 1'b1, VRAM_GLYPH_BASE, 16'hABCD, 1'b0, 14'h0);
    cycle(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, 1'b1, VRAM_GLYPH_BASE);
    n = 0;
    while (n < 9) begin
      n++;
      idle(1);
      if (bus.host_rd_valid) break;
    end
    chk("raw_latency", 32'(n), 32'd3);
    chk("raw_rdata", 32'(bus.host_rdata), 32'hABCD);

    for (int unsigned i = 0; i < 16; i++)
      cycle(1'b0, 14'h0, 1'b1, pool(i), 16'($urandom), 1'b0, 14'h0);
    idle(6);

    // Pending read under a 1,1,1,0 display pattern
    cycle(1'b1, pool(1), 1'b0, 14'h0, 16'h0, 1'b1, 14'h0003);
    cnt = 0;
    for (int unsigned k = 0; k < 12; k++) begin
      de = ((k % 4) != 3);
      cycle(de, pool(k % 16), 1'b0, 14'h0, 16'h0, 1'b0, 14'h0);
      if (bus.host_rd_valid) cnt++;
    end
    chk("pattern_valid_cnt", 32'(cnt), 32'd1);

    // Requests while busy are dropped
    cycle(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, 1'b1, 14'h2001);
    cnt = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      cycle(1'b0, 14'h0, 1'b0, 14'h0, 16'h0, (k < 2), 14'h0005);
      if (bus.host_rd_valid) cnt++;
    end
    chk("busy_req_valid_cnt", 32'(cnt), 32'd1);

    for (int unsigned k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 99) < 55), pool($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 4), pool($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 9) < 2), pool($urandom_range(0, 15)));
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
